// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// uart_tx_frame: parametrised UART transmitter. Each frame is a start bit,
// DATA_BITS data bits sent LSB first, an optional parity bit and 1 or 2 stop bits.
// A one-entry holding register lets frames go out back-to-back with no idle gap.
// Optional line-break generation is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_TX_DV,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_TX_Break,
`endif
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);

`ifdef UART_TX_BREAK_EN
  // A break holds the line low for at least one full frame, counted in bit periods.
  localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] FRAME_FULL = BW'(FRAME_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`endif

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [IW-1:0]          bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   hold_reg, hold_next;
  logic                   hold_full_reg, hold_full_next;
  logic                   serial_reg, serial_next;
  logic                   par_bit;
  logic                   accept;
`ifdef UART_TX_BREAK_EN
  logic [BW-1:0]          brk_cnt_reg, brk_cnt_next;
`endif

`ifdef UART_TX_BREAK_EN
  assign o_TX_Ready  = ~hold_full_reg & (state_reg != S_BREAK);
`else
  assign o_TX_Ready  = ~hold_full_reg;
`endif
  assign accept      = i_TX_DV & o_TX_Ready;
  assign o_TX_Active = (state_reg != S_IDLE);
  assign o_TX_Done   = (state_reg == S_STOP) && (cnt_reg == STOP_LAST);
  assign o_TX_Serial = serial_reg;

  // State, counters, data registers and the registered serial line.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      serial_reg    <= 1'b1;
`ifdef UART_TX_BREAK_EN
      brk_cnt_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      serial_reg    <= serial_next;
`ifdef UART_TX_BREAK_EN
      brk_cnt_reg   <= brk_cnt_next;
`endif
    end
  end

  // Next-state logic; the serial line is decoded from the next state so it is registered.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    serial_next    = 1'b1;
    par_bit        = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_cnt_next   = brk_cnt_reg;
`endif

    // Accept and transfer are exclusive: accept needs an empty hold, transfer a full one.
    if (accept) begin
      hold_next      = i_TX_Byte;
      hold_full_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
`ifdef UART_TX_BREAK_EN
        if (i_TX_Break) begin
          brk_cnt_next = '0;
          state_next   = S_BREAK;
        end else
`endif
        if (hold_full_reg) begin
          shift_next     = hold_reg;
          hold_full_next = 1'b0;
          state_next     = S_START;
        end
      end
      S_START: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = S_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (bit_idx_reg == DATA_LAST) begin
            if (PARITY != 0) state_next = S_PARITY;
            else             state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          state_next = S_STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_reg == STOP_LAST) begin
          cnt_next = '0;
          // A byte already waiting chains straight into the next start bit.
          if (hold_full_reg) begin
            shift_next     = hold_reg;
            hold_full_next = 1'b0;
            state_next     = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (((brk_cnt_reg == FRAME_LAST) && (cnt_reg == BIT_LAST) ||
             (brk_cnt_reg == FRAME_FULL)) && !i_TX_Break) begin
          cnt_next   = '0;
          state_next = S_MARK;
        end else if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (brk_cnt_reg != FRAME_FULL) brk_cnt_next = brk_cnt_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_MARK: begin
        if (cnt_reg == STOP_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase

    par_bit = (PARITY == 1) ? ~(^shift_next) : (^shift_next);

    case (state_next)
      S_START:  serial_next = 1'b0;
      S_DATA:   serial_next = shift_next[bit_idx_next];
      S_PARITY: serial_next = par_bit;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  serial_next = 1'b0;
`endif
      default:  serial_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
// tb_uart_tx_frame: three transmitter configurations driven with random traffic.
// Stimulus predicts each frame's start cycle and bit pattern into a queue; a
// per-instance monitor compares the line, Active, Done and Ready every cycle.
module tb_uart_tx_frame;

  typedef struct {
    int          start;
    int          nb;
    logic [15:0] bits;
    bit          is_brk;
    int          data;
  } seg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit fin [3];

  task automatic chk(input bit ok, input string nm, input int inst, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h at %0t", inst, nm, act, exp, $time);
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_inst
      localparam int CPB = (gi == 0) ? 4 : (gi == 1) ? 3 : 2;
      localparam int DB  = (gi == 0) ? 8 : (gi == 1) ? 7 : 5;
      localparam int PAR = (gi == 0) ? 0 : (gi == 1) ? 1 : 2;
      localparam int SB  = (gi == 0) ? 1 : (gi == 1) ? 2 : 1;
      localparam int FB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
      localparam int FL  = CPB * FB;

      logic          rst_n = 1'b0;
      logic          dv = 1'b0;
      logic          brk = 1'b0;
      logic [DB-1:0] tx_byte = '0;
      logic          ready, active, serial, done;

      int   now    = 0;
      int   e_prev = 0;
      int   hold_a = -1;
      int   hold_s = -1;
      int   brk_b  = -1;
      int   brk_e  = -1;
      seg_t sb [$];

      uart_tx_frame #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)
      ) u_dut (
        .i_Clock    (clk),
        .i_Rst_L    (rst_n),
        .i_TX_DV    (dv),
`ifdef UART_TX_BREAK_EN
        .i_TX_Break (brk),
`endif
        .i_TX_Byte  (tx_byte),
        .o_TX_Ready (ready),
        .o_TX_Active(active),
        .o_TX_Serial(serial),
        .o_TX_Done  (done)
      );

      always @(posedge clk) now <= now + 1;

      // Line pattern of one frame: start 0, data LSB first, parity, stop 1s.
      function automatic logic [15:0] mk_bits(input logic [DB-1:0] d);
        logic [15:0] b;
        int ones;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < DB; i++) b[1 + i] = d[i];
        if (PAR != 0) begin
          ones = $countones(d);
          b[1 + DB] = (PAR == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        end
        return b;
      endfunction

      function automatic bit model_ready(input int n);
        return !(n >= hold_a && n < hold_s) && !(n >= brk_b && n < brk_e);
      endfunction

      task automatic tick();
        @(posedge clk);
        #1;
      endtask

      // Present a byte for the next edge; if the model says Ready, predict its frame.
      task automatic drive(input bit v, input logic [DB-1:0] d);
        seg_t s;
        dv = v;
        tx_byte = d;
        if (v && model_ready(now)) begin
          s.start  = (now + 2 > e_prev) ? now + 2 : e_prev;
          s.nb     = FB;
          s.bits   = mk_bits(d);
          s.is_brk = 1'b0;
          s.data   = int'(d);
          sb.push_back(s);
          hold_a = now + 1;
          hold_s = s.start;
          e_prev = s.start + FL;
        end
      endtask

      task automatic wait_idle();
        while (!(now >= e_prev && model_ready(now))) tick();
      endtask

      // Stimulus: reset, directed frames, overrun, optional break, random, reset mid-frame.
      initial begin
        logic [DB-1:0] d;
        seg_t bs;
        rst_n = 1'b0;
        tick();
        tick();
        chk(serial == 1'b1, "reset_serial", gi, int'(serial), 1);
        chk(active == 1'b0, "reset_active", gi, int'(active), 0);
        chk(ready == 1'b1, "reset_ready", gi, int'(ready), 1);
        chk(done == 1'b0, "reset_done", gi, int'(done), 0);
        rst_n = 1'b1;
        tick();

        d = (gi == 0) ? DB'(8'hA5) : DB'(8'h55);
        drive(1'b1, d);
        tick();
        drive(1'b0, '0);
        wait_idle();

        drive(1'b1, DB'(8'h0F));
        tick();
        drive(1'b0, '0);
        tick();
        tick();
        drive(1'b1, DB'(8'hF0));
        tick();
        repeat (3) begin
          drive(1'b1, DB'(8'h33));
          tick();
        end
        drive(1'b0, '0);
        wait_idle();

`ifdef UART_TX_BREAK_EN
        brk       = 1'b1;
        bs.start  = now + 1;
        bs.nb     = FB + SB;
        bs.bits   = '1;
        for (int i = 0; i < FB; i++) bs.bits[i] = 1'b0;
        bs.is_brk = 1'b1;
        bs.data   = 0;
        sb.push_back(bs);
        brk_b  = now + 1;
        brk_e  = now + 1 + FL;
        e_prev = now + 1 + FL + SB * CPB + 1;
        drive(1'b1, DB'($urandom));
        tick();
        brk = 1'b0;
        drive(1'b0, '0);
        wait_idle();
`else
        bs.start = 0;
`endif

        repeat (600) begin
          d = DB'($urandom);
          drive($urandom_range(0, 3) == 0, d);
          tick();
        end
        drive(1'b0, '0);
        wait_idle();

        drive(1'b1, DB'($urandom));
        tick();
        drive(1'b0, '0);
        repeat (2 * CPB + 1) tick();
        #2;
        rst_n = 1'b0;
        sb.delete();
        hold_a = -1;
        hold_s = -1;
        brk_b  = -1;
        brk_e  = -1;
        e_prev = 0;
        #1;
        chk(serial == 1'b1, "async_rst_serial", gi, int'(serial), 1);
        chk(active == 1'b0, "async_rst_active", gi, int'(active), 0);
        chk(ready == 1'b1, "async_rst_ready", gi, int'(ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        repeat (300) begin
          d = DB'($urandom);
          drive($urandom_range(0, 2) == 0, d);
          tick();
        end
        drive(1'b0, '0);
        wait_idle();
        repeat (3) tick();
        fin[gi] = 1'b1;
      end

      // Monitor: expected line state from the front of the queue, checked every cycle.
      always @(negedge clk) begin
        logic es, ea, ed, er;
        int k;
        while (sb.size() > 0 && now >= sb[0].start + sb[0].nb * CPB) void'(sb.pop_front());
        es = 1'b1;
        ea = 1'b0;
        ed = 1'b0;
        if (sb.size() > 0 && now >= sb[0].start) begin
          k  = (now - sb[0].start) / CPB;
          es = sb[0].bits[k];
          ea = 1'b1;
          ed = !sb[0].is_brk && (now == sb[0].start + FL - 1);
        end
        er = model_ready(now);
        chk({serial, active, done, ready} == {es, ea, ed, er}, "line{ser,act,done,rdy}", gi,
            int'({serial, active, done, ready}), int'({es, ea, ed, er}));
        if (done) begin
          chk(ed == 1'b1, "done_frame_end", gi, 1, int'(ed));
          if (sb.size() > 0)
            $display("inst%0d frame data=0x%0h done at cycle %0d", gi, sb[0].data, now);
        end
      end
    end
  endgenerate

  initial begin
    wait (fin[0] && fin[1] && fin[2]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
